// File: rtl/hazard_pkg.sv
// Shared indices and field layout for the register-hazard tracking pipe.
// Match-vector bit positions are used by both the pipe and hazardUnit.
package hazard_pkg;

    localparam int HZ_RADDR_W = 4;

    localparam int MATCH_12D_E = 4;
    localparam int MATCH_1E_M  = 3;
    localparam int MATCH_2E_M  = 2;
    localparam int MATCH_1E_W  = 1;
    localparam int MATCH_2E_W  = 0;

    typedef struct packed {
        logic [HZ_RADDR_W-1:0] ra1;
        logic [HZ_RADDR_W-1:0] ra2;
        logic [HZ_RADDR_W-1:0] wa3;
        logic                  regWrite;
        logic                  memtoReg;
        logic                  pcSrc;
    } hz_ctrl_t;

endpackage

// File: rtl/hz_stage_reg.sv
// Pipeline stage register: synchronous active-low reset plus a synchronous clear
// that loads an all-zero bubble.
module hz_stage_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_match_pipe.sv
// Carries register numbers and write controls from Decode through E/M/W and produces
// the comparisons and pending-write flags that hazardUnit uses for stall/forward/flush.
module hazard_match_pipe
    import hazard_pkg::*;
#(
    parameter int RADDR_W = HZ_RADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RADDR_W-1:0] RA1D,
    input  logic [RADDR_W-1:0] RA2D,
    input  logic [RADDR_W-1:0] WA3D,
    input  logic               RegWriteD,
    input  logic               MemtoRegD,
    input  logic               PCSrcD,
    input  logic               CondExE,
    input  logic               flushE,
    output logic [4:0]         match,
    output logic               RegWriteM,
    output logic               RegWriteW,
    output logic               MemtoRegE,
    output logic               PCWrPendingF,
    output logic               PCSrcW
);

    localparam int E_W  = 3 * RADDR_W + 3;
    localparam int MW_W = RADDR_W + 2;

    logic [E_W-1:0]     w_e_d;
    logic [E_W-1:0]     w_e_q;
    logic [MW_W-1:0]    w_m_d;
    logic [MW_W-1:0]    w_m_q;
    logic [MW_W-1:0]    w_w_q;

    logic [RADDR_W-1:0] w_ra1e;
    logic [RADDR_W-1:0] w_ra2e;
    logic [RADDR_W-1:0] w_wa3e;
    logic               w_regwritee;
    logic               w_pcsrce;
    logic [RADDR_W-1:0] w_wa3m;
    logic               w_pcsrcm;
    logic [RADDR_W-1:0] w_wa3w;

    assign w_e_d = {RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD};

    // flushE turns the incoming Decode instruction into a bubble.
    hz_stage_reg #(.W(E_W)) u_stage_e (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (flushE),
        .i_d     (w_e_d),
        .o_q     (w_e_q)
    );

    assign {w_ra1e, w_ra2e, w_wa3e, w_regwritee, MemtoRegE, w_pcsrce} = w_e_q;

    // A failed condition squashes the register and PC writes as they leave E.
    assign w_m_d = {w_wa3e, w_regwritee & CondExE, w_pcsrce & CondExE};

    hz_stage_reg #(.W(MW_W)) u_stage_m (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (1'b0),
        .i_d     (w_m_d),
        .o_q     (w_m_q)
    );

    assign {w_wa3m, RegWriteM, w_pcsrcm} = w_m_q;

    hz_stage_reg #(.W(MW_W)) u_stage_w (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (1'b0),
        .i_d     (w_m_q),
        .o_q     (w_w_q)
    );

    assign {w_wa3w, RegWriteW, PCSrcW} = w_w_q;

    // Raw equality only; hazardUnit qualifies each bit with the matching write enable.
    always_comb begin
        match              = '0;
        match[MATCH_12D_E] = (RA1D == w_wa3e) || (RA2D == w_wa3e);
        match[MATCH_1E_M]  = (w_ra1e == w_wa3m);
        match[MATCH_2E_M]  = (w_ra2e == w_wa3m);
        match[MATCH_1E_W]  = (w_ra1e == w_wa3w);
        match[MATCH_2E_W]  = (w_ra2e == w_wa3w);
    end

    // The E term is deliberately not condition-gated so a pending branch is never missed.
    assign PCWrPendingF = PCSrcD | w_pcsrce | w_pcsrcm;

endmodule
